load_bmp: RTL and testbench

- Byte-serial copy engine. Streams a complete BMP image (header plus pixel data) from a synchronous read-only image store (bmp_rom) into a write-only image buffer (bmp_ram).
- Sits between the two memories in the image-load path and raises done once the last byte has been committed.
- Downstream processing or dump logic keys off the rising edge of done.

---
 rtl/load_bmp_pkg.sv | 21 ++
 rtl/load_bmp.sv | 96 +++++++++
 tb/tb_load_bmp.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/load_bmp_pkg.sv
// Shared constants and FSM encoding for the BMP image-load path.
package load_bmp_pkg;

  // Default geometry: 512x512 24-bit BMP with a 54-byte header.
  localparam int unsigned BYTE_WIDTH      = 8;
  localparam int unsigned ADDR_WIDTH      = 20;
  localparam int unsigned BMP_HEADER_SIZE = 54;
  localparam int unsigned BMP_TOTAL_SIZE  = 786486;

  // Image file paths consumed by bmp_rom and produced by the dump logic.
  localparam string BMP_IN_FILE  = "img/input_bmp.hex";
  localparam string BMP_OUT_FILE = "img/output_bmp.hex";

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StFinish
  } state_e;

endpackage

// File: rtl/load_bmp.sv
// Byte-serial copy engine: streams BMP_TOTAL_SIZE bytes from bmp_rom into bmp_ram,
// one byte per clock, then raises a sticky done.
module load_bmp #(
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned BMP_TOTAL_SIZE = 786486
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] ROM_Q,
    output logic                  ROM_valid,
    output logic [ADDR_WIDTH-1:0] ROM_addr,
    output logic                  RAM_valid,
    output logic [BYTE_WIDTH-1:0] RAM_D,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic                  done
);
    import load_bmp_pkg::*;

    // Last address compared at full width so the counter never wraps mid-copy.
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(BMP_TOTAL_SIZE - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                  in_valid_q, in_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rom_req;
    logic [ADDR_WIDTH-1:0] rom_req_addr;

    // Next-state, read counter and ROM request generation.
    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        rom_req      = 1'b0;
        rom_req_addr = '0;
        unique case (state_q)
            StIdle: begin
                state_d = StRead;
            end
            StRead: begin
                rom_req      = 1'b1;
                rom_req_addr = rd_cnt_q;
                if (rd_cnt_q == LastAddr) begin
                    state_d  = StDrain;
                    rd_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
                end
            end
            // The final ROM byte is being written this cycle.
            StDrain: begin
                state_d = StFinish;
            end
            StFinish: begin
                state_d = StFinish;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Write pipeline: the request of this cycle becomes the write of the next.
    always_comb begin
        in_valid_d = rom_req;
        wr_addr_d  = rom_req_addr;
    end

    // State, counter and write-pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rd_cnt_q   <= '0;
            in_valid_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            in_valid_q <= in_valid_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    // Outputs; RAM_D is gated so stale ROM data never leaks outside a write.
    always_comb begin
        ROM_valid = rom_req;
        ROM_addr  = rom_req_addr;
        in_valid  = in_valid_q;
        RAM_valid = in_valid_q;
        RAM_addr  = in_valid_q ? wr_addr_q : '0;
        RAM_D     = in_valid_q ? ROM_Q : '0;
        done      = (state_q == StFinish);
    end

endmodule

// File: tb/tb_load_bmp.sv
// Self-checking bench for load_bmp: an 8-byte and a 1-byte instance share clock and reset.
module tb_load_bmp;

    localparam int NA = 8;
    localparam int NB = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv_a, rv_a, wv_a, dn_a;
    logic [19:0] ra_a, wa_a;
    logic [7:0]  wd_a, rom_q_a;
    logic        iv_b, rv_b, wv_b, dn_b;
    logic [19:0] ra_b, wa_b;
    logic [7:0]  wd_b, rom_q_b;

    logic [7:0]  rom_a [NA];
    logic [7:0]  ram_a [NA];
    logic [7:0]  rom_b [NB];
    logic [7:0]  ram_b [NB];
    int          wr_cnt = 0;

    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    load_bmp #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_TOTAL_SIZE(NA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .ROM_Q(rom_q_a), .ROM_valid(rv_a),
        .ROM_addr(ra_a), .RAM_valid(wv_a), .RAM_D(wd_a), .RAM_addr(wa_a), .done(dn_a)
    );

    load_bmp #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_TOTAL_SIZE(NB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .ROM_Q(rom_q_b), .ROM_valid(rv_b),
        .ROM_addr(ra_b), .RAM_valid(wv_b), .RAM_D(wd_b), .RAM_addr(wa_b), .done(dn_b)
    );

    // Registered ROMs and write-only RAMs around the two instances.
    always @(posedge clk) begin
        if (rv_a) rom_q_a <= rom_a[ra_a[2:0]];
        if (rv_b) rom_q_b <= rom_b[0];
        if (wv_a) begin
            ram_a[wa_a[2:0]] <= wd_a;
            wr_cnt <= wr_cnt + 1;
        end
        if (wv_b) ram_b[0] <= wd_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // c = cycles since the copy started (cycle 0 carries the first request); c < 0 means reset.
    task automatic check_cyc(input string tag, input int n, input int c, input logic [7:0] exp_d,
                             input logic rv, input logic [19:0] ra, input logic iv,
                             input logic wv, input logic [19:0] wa, input logic [7:0] wd,
                             input logic dn);
        bit req;
        bit wr;
        req = (c >= 0) && (c < n);
        wr  = (c >= 1) && (c <= n);
        chk({tag, ".rom_valid"}, {31'd0, rv}, {31'd0, req});
        chk({tag, ".rom_addr"},  {12'd0, ra}, req ? c : 0);
        chk({tag, ".in_valid"},  {31'd0, iv}, {31'd0, wr});
        chk({tag, ".ram_valid"}, {31'd0, wv}, {31'd0, wr});
        chk({tag, ".ram_addr"},  {12'd0, wa}, wr ? c - 1 : 0);
        chk({tag, ".ram_d"},     {24'd0, wd}, wr ? {24'd0, exp_d} : 0);
        chk({tag, ".done"},      {31'd0, dn}, {31'd0, (c >= n + 1)});
    endtask

    task automatic check_both(input int c);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = (c >= 1 && c <= NA) ? rom_a[c-1] : 8'h00;
        eb = (c == 1) ? rom_b[0] : 8'h00;
        check_cyc("a", NA, c, ea, rv_a, ra_a, iv_a, wv_a, wa_a, wd_a, dn_a);
        check_cyc("b", NB, c, eb, rv_b, ra_b, iv_b, wv_b, wa_b, wd_b, dn_b);
    endtask

    // Called at a negedge right after rst_n rises; samples cycles 0..cycles-1.
    task automatic run_copy(input int cycles, output int rises);
        logic pd;
        pd    = 1'b0;
        rises = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_both(c);
            if (dn_a && !pd) rises++;
            pd = dn_a;
        end
    endtask

    task automatic check_ram();
        for (int i = 0; i < NA; i++) chk($sformatf("ram_a[%0d]", i), {24'd0, ram_a[i]},
                                         {24'd0, rom_a[i]});
        chk("ram_b[0]", {24'd0, ram_b[0]}, {24'd0, rom_b[0]});
    endtask

    task automatic randomize_roms();
        for (int i = 0; i < NA; i++) rom_a[i] = 8'($urandom_range(0, 255));
        rom_b[0] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int rises;
        int wr_snap;

        // Reset held low: no traffic, done low.
        rom_a[0] = 8'h42; rom_a[1] = 8'h4D; rom_a[2] = 8'h10; rom_a[3] = 8'h20;
        rom_a[4] = 8'h30; rom_a[5] = 8'h40; rom_a[6] = 8'h50; rom_a[7] = 8'h60;
        rom_b[0] = 8'hA5;
        wr_snap = wr_cnt;
        repeat (50) begin
            @(negedge clk);
            check_both(-1);
        end
        chk("reset_no_writes", wr_cnt, wr_snap);

        // Nominal directed copy.
        rst_n = 1'b1;
        run_copy(NA + 6, rises);
        chk("nominal.done_rises", rises, 1);
        check_ram();

        // Reset asserted during cycle 4 of a fresh random copy, released 3 cycles later.
        @(negedge clk);
        rst_n = 1'b0;
        randomize_roms();
        @(negedge clk);
        rst_n = 1'b1;
        run_copy(5, rises);
        #1 rst_n = 1'b0;
        #1 check_both(-1);
        repeat (3) begin
            @(negedge clk);
            check_both(-1);
        end
        rst_n = 1'b1;
        run_copy(NA + 5, rises);
        chk("restart.done_rises", rises, 1);
        check_ram();

        // Further randomized copies.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst_n = 1'b0;
            randomize_roms();
            @(negedge clk);
            check_both(-1);
            rst_n = 1'b1;
            run_copy(NA + 4, rises);
            chk("rand.done_rises", rises, 1);
            check_ram();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
